// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART byte transmitter between NUM_REQ requesters using
// round-robin arbitration. The granted byte is registered onto tx_din and
// tx_send is held until the transmitter reports busy. Then send is dropped
// and the arbiter waits for busy to clear before the next grant.
// If tx_send stays high for ACK_TIMEOUT cycles without busy, err pulses and
// the request is arbitrated again.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   req          per-requester level request (held until ack)
//   req_data     byte of requester i at [8*i+7:8*i]
//   ack          one-cycle, one-hot pulse when a requester's byte is accepted
//   tx_send      send strobe to the transmitter
//   tx_din       byte to the transmitter, stable while tx_send is high
//   tx_busy      transmitter busy
//   owner        index of the current grant holder
//   owner_valid  high while a grant is held (SEND and WAIT)
//   err          one-cycle pulse on acknowledge timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_send,
  output logic [7:0]                 tx_din,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       owner_valid,
  output logic                       err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT);

  typedef logic [OW-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  state_e               state_q, state_d;
  idx_t                 last_q, last_d;
  idx_t                 owner_q, owner_d;
  logic [7:0]           din_q, din_d;
  logic                 send_q, send_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 ovalid_q, ovalid_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Round-robin pick: first requester after the previous owner, wrapping.
  idx_t winner;
  idx_t cand;
  logic found;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    winner = last_q;
    cand   = '0;
    found  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = idx_t'((int'(last_q) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    din_d    = din_q;
    cnt_d    = cnt_q;
    send_d   = 1'b0;
    ack_d    = '0;
    ovalid_d = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A busy transmitter is still finishing the previous byte.
        if (found && !tx_busy) begin
          state_d  = S_SEND;
          owner_d  = winner;
          din_d    = req_data[{winner, 3'b000} +: 8];
          cnt_d    = '0;
          send_d   = 1'b1;
          ovalid_d = 1'b1;
        end
      end
      S_SEND: begin
        if (tx_busy) begin
          state_d  = S_WAIT;
          ack_d    = NUM_REQ'(1) << owner_q;
          ovalid_d = 1'b1;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // Give up on this attempt; the still-pending request competes
          // again from behind the other requesters.
          state_d = S_IDLE;
          last_d  = owner_q;
          err_d   = 1'b1;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          send_d   = 1'b1;
          ovalid_d = 1'b1;
        end
      end
      S_WAIT: begin
        // Send stays low here so the transmitter can leave its done state.
        if (!tx_busy) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end else begin
          ovalid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the values from before the edge, independent of ordering.
    if (!rst) begin
      state_q  <= S_IDLE;
      last_q   <= idx_t'(NUM_REQ - 1);
      owner_q  <= '0;
      din_q    <= '0;
      send_q   <= 1'b0;
      ack_q    <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      din_q    <= din_d;
      send_q   <= send_d;
      ack_q    <= ack_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign tx_send     = send_q;
  assign tx_din      = din_q;
  assign owner       = owner_q;
  assign owner_valid = ovalid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed requester scenarios, a behavioural
// transmitter, and a scoreboard of expected (owner, byte) acceptances that a
// monitor checks on every ack pulse.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        tx_send;
  logic [7:0]  tx_din;
  logic        tx_busy = 1'b0;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        err;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_send    (tx_send),
    .tx_din     (tx_din),
    .tx_busy    (tx_busy),
    .owner      (owner),
    .owner_valid(owner_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Transmitter model control: 0 = responsive, 1 = dead (never busy),
  // 2 = stuck busy.
  int         tx_mode  = 0;
  int         tx_phase = 0;
  int         tx_cnt   = 0;
  logic [7:0] rx_last  = '0;
  bit         err_allowed = 1'b0;

  int cnt_left[NUM_REQ] = '{default: 0};
  int start_at[NUM_REQ] = '{default: 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Transmitter: raises busy two cycles after seeing send, holds it ten
  // cycles, and records the byte it latched.
  always @(negedge clk) begin
    if (tx_mode == 2) begin
      tx_busy  = 1'b1;
      tx_phase = 0;
    end else if (tx_mode == 1) begin
      tx_busy  = 1'b0;
      tx_phase = 0;
    end else begin
      case (tx_phase)
        0: begin
          tx_busy = 1'b0;
          if (tx_send) begin
            tx_phase = 1;
            tx_cnt   = 2;
          end
        end
        1: begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            tx_busy  = 1'b1;
            rx_last  = tx_din;
            tx_phase = 2;
            tx_cnt   = 10;
          end
        end
        default: begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            tx_busy  = 1'b0;
            tx_phase = 0;
          end
        end
      endcase
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", ack, 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_vec", ack, 32'(4'b0001 << e.owner));
        check("ack_owner", owner, e.owner);
        check("ack_tx_din", tx_din, e.data);
        check("ack_rx_byte", rx_last, e.data);
      end
    end
    if (err === 1'b1 && !err_allowed) check("err_unexpected", err, 0);
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive requesters from cnt_left/start_at until every byte is acked.
  task automatic run_bytes(input int max_cycles);
    int acks = 0;
    bit done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        req[i] = (cnt_left[i] > 0) && (acks >= start_at[i]);
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] && cnt_left[i] > 0) begin
          cnt_left[i]--;
          acks++;
        end
      end
      done = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (cnt_left[i] != 0) done = 1'b0;
    end
    req = '0;
    check("run_done", done, 1);
    for (int c = 0; c < 60 && (owner_valid || tx_phase != 0); c++) @(negedge clk);
    check("drain_idle", owner_valid, 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int hi, errs, acks;

    // Reset held with all requests pending.
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_tx_send", tx_send, 0);
      check("rst_ack", ack, 0);
      check("rst_owner_valid", owner_valid, 0);
      check("rst_err", err, 0);
    end
    req = '0;

    // Single request from requester 2.
    do_reset();
    req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    expect_byte(2'd2, 8'hA5);
    req = 4'b0100;
    @(negedge clk);
    check("single_latency_send", tx_send, 1);
    check("single_tx_din", tx_din, 8'hA5);
    check("single_owner", owner, 2);
    check("single_owner_valid", owner_valid, 1);
    cnt_left = '{0, 0, 1, 0};
    start_at = '{0, 0, 0, 0};
    run_bytes(200);

    // Round-robin with all four requesting two bytes each.
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++)
        expect_byte(2'(i), 8'(8'h10 + i));
    cnt_left = '{2, 2, 2, 2};
    start_at = '{0, 0, 0, 0};
    run_bytes(400);

    // Requester 3 joins while requester 0 streams.
    do_reset();
    expect_byte(2'd0, 8'h10);
    expect_byte(2'd3, 8'h13);
    expect_byte(2'd0, 8'h10);
    expect_byte(2'd3, 8'h13);
    cnt_left = '{2, 0, 0, 2};
    start_at = '{0, 0, 0, 1};
    run_bytes(400);

    // Dead transmitter: timeout, then re-grant to the same requester.
    do_reset();
    tx_mode = 1;
    err_allowed = 1'b1;
    req = 4'b0010;
    hi = 0; errs = 0; acks = 0;
    for (int c = 0; c < 40 && errs == 0; c++) begin
      @(negedge clk);
      if (tx_send) hi++;
      if (err) errs++;
      if (ack != '0) acks++;
    end
    check("timeout_send_cycles", hi, ACK_TIMEOUT);
    check("timeout_err_pulse", errs, 1);
    check("timeout_no_ack", acks, 0);
    @(negedge clk);
    check("timeout_err_single", err, 0);
    check("regrant_send", tx_send, 1);
    check("regrant_owner", owner, 1);
    err_allowed = 1'b0;
    expect_byte(2'd1, 8'h11);
    tx_mode = 0;
    cnt_left = '{0, 1, 0, 0};
    start_at = '{0, 0, 0, 0};
    run_bytes(100);

    // Reset while sending, then transmitter busy at reset release.
    do_reset();
    tx_mode = 1;
    req = 4'b0001;
    for (int c = 0; c < 10 && !tx_send; c++) @(negedge clk);
    check("midsend_active", tx_send, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midsend_rst_send", tx_send, 0);
    check("midsend_rst_owner_valid", owner_valid, 0);
    check("midsend_rst_ack", ack, 0);
    tx_mode = 2;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("busy_idle_no_grant", tx_send, 0);
    end
    expect_byte(2'd0, 8'h10);
    tx_mode = 0;
    cnt_left = '{1, 0, 0, 0};
    start_at = '{0, 0, 0, 0};
    run_bytes(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
